// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter family.
//   - Terminal-behaviour mode constants (WRAP / SATURATE / ONESHOT)
//   - Two-state ONESHOT FSM encoding
//   - Binary-to-Gray helper, used when MOD_COUNTER_GRAY_OUT_EN is defined
package counter_pkg;

    localparam int unsigned MODE_WRAP     = 0;
    localparam int unsigned MODE_SATURATE = 1;
    localparam int unsigned MODE_ONESHOT  = 2;

    // Width of the Gray helper; callers cast in/out to their own width.
    localparam int unsigned GRAY_W = 32;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Upper bits are zero-extended by the caller, so truncating the result
    // back to the caller's width gives the correct Gray code.
    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Parametrised synchronous up/down modulo counter.
// Optional feature macro: MOD_COUNTER_GRAY_OUT_EN (adds registered count_gray).
//
// Ports:
//   clk         rising-edge clock for all state
//   rst         synchronous active-high reset
//   en          count enable, one step per enabled cycle
//   up_dn       1 = count up, 0 = count down
//   clear       synchronous clear to RST_VALUE
//   load        parallel load strobe (load_val clamped to MOD_VALUE-1)
//   load_val    value for load
//   count       registered count, 0..MOD_VALUE-1
//   tc          combinational terminal count for the current direction
//   ovf         registered pulse after a wrap or saturate-attempt step
//   halted      registered, high while the ONESHOT FSM is halted
//   count_gray  (macro only) registered Gray code of count
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MOD_VALUE = 16,
    parameter int unsigned     MODE      = 0,
    parameter int unsigned     RST_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
`ifdef MOD_COUNTER_GRAY_OUT_EN
    output logic [WIDTH-1:0] count_gray,
`endif
    output logic             halted
);

    localparam int unsigned   EXT_W  = WIDTH + 1;
    localparam logic [WIDTH:0] LP_MAX = EXT_W'(MOD_VALUE - 64'd1);
    localparam logic [WIDTH:0] LP_RST = EXT_W'(RST_VALUE);
    localparam logic [WIDTH:0] LP_ONE = EXT_W'(1);

    // Elaboration-time parameter legality
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "mod_counter: WIDTH must be in 2..32");
    end
    if (MOD_VALUE < 64'd2 || MOD_VALUE > (64'd1 << WIDTH)) begin : g_bad_mod
        $fatal(1, "mod_counter: MOD_VALUE must be in 2..2**WIDTH");
    end
    if (64'(RST_VALUE) >= MOD_VALUE) begin : g_bad_rst
        $fatal(1, "mod_counter: RST_VALUE must be below MOD_VALUE");
    end
    if (MODE > MODE_ONESHOT) begin : g_bad_mode
        $fatal(1, "mod_counter: MODE must be 0, 1 or 2");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_halted;
    state_e           r_state;

    state_e           w_state_nxt;
    logic [WIDTH:0]   w_count_ext;
    logic [WIDTH:0]   w_ext_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_ovf_nxt;
    logic             w_tc;

    // Arithmetic is done one bit wider so an up step never rolls over silently
    assign w_count_ext = {1'b0, r_count};

    // Terminal count for the direction currently requested
    assign w_tc = up_dn ? (w_count_ext == LP_MAX) : (r_count == '0);

    // Next-state, next-count and pulse decode; priority clear > load > en
    always_comb begin
        w_state_nxt = r_state;
        w_ext_nxt   = w_count_ext;
        w_ovf_nxt   = 1'b0;

        if (clear) begin
            w_ext_nxt   = LP_RST;
            w_state_nxt = ST_RUN;
        end else if (load) begin
            w_ext_nxt   = {1'b0, load_val};
            w_state_nxt = ST_RUN;
        end else if (en) begin
            case (r_state)
                ST_RUN: begin
                    if (!w_tc) begin
                        w_ext_nxt = up_dn ? (w_count_ext + LP_ONE) : (w_count_ext - LP_ONE);
                    end else begin
                        w_ovf_nxt = 1'b1;
                        if (MODE == MODE_WRAP) begin
                            w_ext_nxt = up_dn ? '0 : LP_MAX;
                        end else if (MODE == MODE_ONESHOT) begin
                            w_state_nxt = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    w_ext_nxt = w_count_ext;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Single clamp stage: only a load can exceed the modulus, steps never do
    assign w_count_nxt = (w_ext_nxt > LP_MAX) ? LP_MAX[WIDTH-1:0] : w_ext_nxt[WIDTH-1:0];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= WIDTH'(RST_VALUE);
            r_ovf    <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_ovf    <= w_ovf_nxt;
            r_halted <= (w_state_nxt == ST_HALT);
        end
    end

`ifdef MOD_COUNTER_GRAY_OUT_EN
    logic [WIDTH-1:0] r_count_gray;

    // Encoded from the next count so it lands in the same cycle as count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_gray <= WIDTH'(bin2gray(GRAY_W'(RST_VALUE)));
        end else begin
            r_count_gray <= WIDTH'(bin2gray(GRAY_W'(w_count_nxt)));
        end
    end

    assign count_gray = r_count_gray;
`endif

    assign count  = r_count;
    assign tc     = w_tc;
    assign ovf    = r_ovf;
    assign halted = r_halted;

endmodule
